// File: rtl/sobel_linebuf_ctrl.sv
// Read/write sequencer for the four line buffers feeding a 3x3 Sobel window.
// Pixels fill one buffer at a time; three full buffers are read in parallel per output line.
module sobel_linebuf_ctrl #(
    parameter int IMG_WIDTH = 512,
    parameter int CNT_W     = 12
) (
    input  logic             s_aclk,
    input  logic             s_aresetn,
    input  logic             s_pix_valid,
    output logic             s_pix_ready,
    output logic [3:0]       lb_wr_en,
    output logic [3:0]       lb_rd_en,
    output logic [1:0]       rd_sel,
    input  logic             out_prog_full,
    output logic             o_pix_valid,
    output logic             o_intr,
    output logic             dbg_state,
    output logic [CNT_W-1:0] dbg_stored_cnt
);

    localparam int PIX_W = $clog2(IMG_WIDTH);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(IMG_WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(4 * IMG_WIDTH);
    localparam logic [CNT_W-1:0] WIN_CNT  = CNT_W'(3 * IMG_WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        RD   = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       wr_idx;
    logic [1:0]       rd_idx;
    logic [PIX_W-1:0] wr_pix_cnt;
    logic [PIX_W-1:0] rd_pix_cnt;
    logic [CNT_W-1:0] stored_cnt;
    logic             wr;
    logic             rd;
    logic             rd_last;

    // Handshake: a pixel transfers on a cycle where s_pix_valid and s_pix_ready are both high;
    // ready depends only on the registered fill level, never on valid.
    assign s_pix_ready = (stored_cnt != FULL_CNT);
    assign wr          = s_pix_valid & s_pix_ready;
    assign rd          = (state == RD) & ~out_prog_full;
    assign rd_last     = rd & (rd_pix_cnt == LAST_PIX);

    assign rd_sel         = rd_idx;
    assign dbg_state      = (state == RD);
    assign dbg_stored_cnt = stored_cnt;

    // Strobe is masked while reset is held so a buffer is never written during reset.
    always_comb begin
        lb_wr_en = 4'b0000;
        if (wr && s_aresetn) begin
            lb_wr_en[wr_idx] = 1'b1;
        end
    end

    always_comb begin
        lb_rd_en = 4'b0000;
        if (rd) begin
            lb_rd_en[rd_idx]        = 1'b1;
            lb_rd_en[rd_idx + 2'd1] = 1'b1;
            lb_rd_en[rd_idx + 2'd2] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if ((stored_cnt >= WIN_CNT) && !out_prog_full) state_nxt = RD;
            RD:   if (rd_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            wr_idx     <= 2'd0;
            wr_pix_cnt <= '0;
        end else if (wr) begin
            if (wr_pix_cnt == LAST_PIX) begin
                wr_pix_cnt <= '0;
                wr_idx     <= wr_idx + 2'd1;
            end else begin
                wr_pix_cnt <= wr_pix_cnt + PIX_W'(1);
            end
        end
    end

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            rd_idx     <= 2'd0;
            rd_pix_cnt <= '0;
        end else if (rd) begin
            if (rd_last) begin
                rd_pix_cnt <= '0;
                rd_idx     <= rd_idx + 2'd1;
            end else begin
                rd_pix_cnt <= rd_pix_cnt + PIX_W'(1);
            end
        end
    end

    // Each window column consumes one pixel of the oldest buffer, so a full line frees one buffer.
    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            stored_cnt <= '0;
        end else begin
            case ({wr, rd})
                2'b10:   stored_cnt <= stored_cnt + CNT_W'(1);
                2'b01:   stored_cnt <= stored_cnt - CNT_W'(1);
                default: stored_cnt <= stored_cnt;
            endcase
        end
    end

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            o_pix_valid <= 1'b0;
            o_intr      <= 1'b0;
        end else begin
            o_pix_valid <= rd;
            o_intr      <= rd_last;
        end
    end

endmodule

// File: tb/tb_sobel_linebuf_ctrl.sv
// Directed bench for sobel_linebuf_ctrl with IMG_WIDTH=8; a queue holds the expected
// read strobe / rd_sel for every window column, filled as lines complete.
module tb_sobel_linebuf_ctrl;

    localparam int W     = 8;
    localparam int CNT_W = 12;

    logic             s_aclk = 1'b0;
    logic             s_aresetn = 1'b1;
    logic             s_pix_valid = 1'b0;
    logic             s_pix_ready;
    logic [3:0]       lb_wr_en;
    logic [3:0]       lb_rd_en;
    logic [1:0]       rd_sel;
    logic             out_prog_full = 1'b0;
    logic             o_pix_valid;
    logic             o_intr;
    logic             dbg_state;
    logic [CNT_W-1:0] dbg_stored_cnt;

    logic [5:0] exp_q[$];
    int n_assert = 0;
    int n_fail   = 0;
    int wr_total = 0;
    int intr_cnt = 0;

    sobel_linebuf_ctrl #(.IMG_WIDTH(W), .CNT_W(CNT_W)) dut (
        .s_aclk         (s_aclk),
        .s_aresetn      (s_aresetn),
        .s_pix_valid    (s_pix_valid),
        .s_pix_ready    (s_pix_ready),
        .lb_wr_en       (lb_wr_en),
        .lb_rd_en       (lb_rd_en),
        .rd_sel         (rd_sel),
        .out_prog_full  (out_prog_full),
        .o_pix_valid    (o_pix_valid),
        .o_intr         (o_intr),
        .dbg_state      (dbg_state),
        .dbg_stored_cnt (dbg_stored_cnt)
    );

    always #5 s_aclk = ~s_aclk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge s_aclk);
        #1;
    endtask

    // Checks one offered pixel against the write model and queues the reads a completed line unlocks.
    task automatic chk_wr(input logic acc);
        logic [3:0] oh;
        logic [5:0] e;
        int ln;
        int r;
        ln = wr_total / W;
        oh = 4'b0000;
        oh[ln % 4] = 1'b1;
        chk("s_pix_ready", {15'd0, s_pix_ready}, {15'd0, acc});
        chk("lb_wr_en", {12'd0, lb_wr_en}, acc ? {12'd0, oh} : 16'd0);
        if (acc) begin
            wr_total++;
            if ((wr_total % W == 0) && (wr_total >= 3 * W)) begin
                r = (wr_total / W - 3) % 4;
                e = 6'd0;
                e[5:4] = r[1:0];
                for (int j = 0; j < 3; j++) e[(r + j) % 4] = 1'b1;
                for (int j = 0; j < W; j++) exp_q.push_back(e);
            end
        end
    endtask

    task automatic do_reset();
        s_aresetn = 1'b0;
        s_pix_valid = 1'b0;
        out_prog_full = 1'b0;
        exp_q.delete();
        wr_total = 0;
        intr_cnt = 0;
        step();
        step();
        s_aresetn = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 80) begin
            step();
            n++;
        end
        chk("drain_queue_empty", exp_q.size(), 16'd0);
        repeat (3) step();
    endtask

    // Scoreboard: every read strobe must match the next queued column.
    always @(negedge s_aclk) begin
        logic [5:0] e;
        if (s_aresetn === 1'b1) begin
            if (o_intr === 1'b1) intr_cnt++;
            if (lb_rd_en !== 4'b0000) begin
                if (exp_q.size() == 0) begin
                    chk("rd_unexpected", {12'd0, lb_rd_en}, 16'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_lb_rd_en", {12'd0, lb_rd_en}, {12'd0, e[3:0]});
                    chk("sb_rd_sel", {14'd0, rd_sel}, {14'd0, e[5:4]});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nv;
        #2 s_aresetn = 1'b0;

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            s_pix_valid   = 1'($urandom_range(0, 1));
            out_prog_full = 1'($urandom_range(0, 1));
            @(negedge s_aclk);
            chk("rst_ready", {15'd0, s_pix_ready}, 16'd1);
            chk("rst_wr_en", {12'd0, lb_wr_en}, 16'd0);
            chk("rst_rd_en", {12'd0, lb_rd_en}, 16'd0);
            chk("rst_pix_valid", {15'd0, o_pix_valid}, 16'd0);
            chk("rst_intr", {15'd0, o_intr}, 16'd0);
            chk("rst_rd_sel", {14'd0, rd_sel}, 16'd0);
            chk("rst_stored", {4'd0, dbg_stored_cnt}, 16'd0);
            step();
        end
        s_pix_valid = 1'b0;
        out_prog_full = 1'b0;
        s_aresetn = 1'b1;
        step();

        // Fill three lines back-to-back, then one line is read
        for (int i = 0; i < 3 * W; i++) begin
            s_pix_valid = 1'b1;
            @(negedge s_aclk);
            chk_wr(1'b1);
            chk("fill_no_rd", {12'd0, lb_rd_en}, 16'd0);
            step();
        end
        s_pix_valid = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            @(negedge s_aclk);
            chk("fill_rd_active", {15'd0, lb_rd_en != 4'b0000}, {15'd0, (k >= 1 && k <= 8)});
            chk("fill_pix_valid", {15'd0, o_pix_valid}, {15'd0, (k >= 2 && k <= 9)});
            chk("fill_intr", {15'd0, o_intr}, {15'd0, (k == 9)});
            chk("fill_rd_sel", {14'd0, rd_sel}, (k >= 9) ? 16'd1 : 16'd0);
            if (k == 9) chk("fill_stored", {4'd0, dbg_stored_cnt}, 16'd16);
            step();
        end
        chk("fill_intr_count", intr_cnt[15:0], 16'd1);

        // Backpressure: five stalled cycles after the third read of the next line
        for (int i = 0; i < W; i++) begin
            s_pix_valid = 1'b1;
            @(negedge s_aclk);
            chk_wr(1'b1);
            step();
        end
        s_pix_valid = 1'b0;
        nv = 0;
        for (int k = 0; k <= 15; k++) begin
            out_prog_full = (k >= 4 && k <= 8);
            @(negedge s_aclk);
            chk("bp_rd_active", {15'd0, lb_rd_en != 4'b0000},
                {15'd0, ((k >= 1 && k <= 3) || (k >= 9 && k <= 13))});
            chk("bp_pix_valid", {15'd0, o_pix_valid},
                {15'd0, ((k >= 2 && k <= 4) || (k >= 10 && k <= 14))});
            chk("bp_intr", {15'd0, o_intr}, {15'd0, (k == 14)});
            if (o_pix_valid === 1'b1) nv++;
            if (k == 14) chk("bp_rd_sel", {14'd0, rd_sel}, 16'd2);
            step();
        end
        out_prog_full = 1'b0;
        chk("bp_valid_count", nv[15:0], 16'd8);
        chk("bp_intr_count", intr_cnt[15:0], 16'd2);

        // Full: reads blocked, 40 pixels offered, 32 accepted
        do_reset();
        out_prog_full = 1'b1;
        for (int i = 0; i < 40; i++) begin
            s_pix_valid = 1'b1;
            @(negedge s_aclk);
            chk_wr(i < 32);
            chk("full_no_rd", {12'd0, lb_rd_en}, 16'd0);
            step();
        end
        out_prog_full = 1'b0;
        @(negedge s_aclk);
        chk("full_stored", {4'd0, dbg_stored_cnt}, 16'd32);
        chk("full_state_idle", {15'd0, dbg_state}, 16'd0);
        chk_wr(1'b0);
        step();
        @(negedge s_aclk);
        chk("full_state_rd", {15'd0, dbg_state}, 16'd1);
        chk_wr(1'b0);
        step();
        @(negedge s_aclk);
        chk_wr(1'b1);
        step();
        s_pix_valid = 1'b0;
        drain();
        chk("full_end_stored", {4'd0, dbg_stored_cnt}, 16'd17);
        chk("full_end_intr", intr_cnt[15:0], 16'd2);

        // Wrap: six lines streamed continuously, four reads rotating through all buffers
        do_reset();
        for (int i = 0; i < 6 * W; i++) begin
            s_pix_valid = 1'b1;
            @(negedge s_aclk);
            chk_wr(1'b1);
            step();
        end
        s_pix_valid = 1'b0;
        drain();
        chk("wrap_intr_count", intr_cnt[15:0], 16'd4);
        chk("wrap_stored", {4'd0, dbg_stored_cnt}, 16'd16);
        chk("wrap_rd_sel", {14'd0, rd_sel}, 16'd0);

        // Reset in the middle of a line read
        do_reset();
        for (int i = 0; i < 3 * W; i++) begin
            s_pix_valid = 1'b1;
            @(negedge s_aclk);
            chk_wr(1'b1);
            step();
        end
        s_pix_valid = 1'b0;
        for (int k = 0; k < 5; k++) step();
        s_aresetn = 1'b0;
        exp_q.delete();
        wr_total = 0;
        #1;
        chk("mid_rst_rd_en", {12'd0, lb_rd_en}, 16'd0);
        chk("mid_rst_wr_en", {12'd0, lb_wr_en}, 16'd0);
        chk("mid_rst_pix_valid", {15'd0, o_pix_valid}, 16'd0);
        chk("mid_rst_intr", {15'd0, o_intr}, 16'd0);
        chk("mid_rst_rd_sel", {14'd0, rd_sel}, 16'd0);
        chk("mid_rst_stored", {4'd0, dbg_stored_cnt}, 16'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge s_aclk);
            chk("mid_rst_hold_intr", {15'd0, o_intr}, 16'd0);
            step();
        end
        s_aresetn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge s_aclk);
            chk("post_rst_intr", {15'd0, o_intr}, 16'd0);
            chk("post_rst_no_rd", {12'd0, lb_rd_en}, 16'd0);
            step();
        end
        s_pix_valid = 1'b1;
        @(negedge s_aclk);
        chk_wr(1'b1);
        step();
        s_pix_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
